pattern_scan_ctrl: RTL and testbench

Sequencer for the serial pattern detector (the 001-then-1010 FSM). It loads a parallel word and presents it to the detector one bit at a time, MSB first, at a programmable step rate. It issues the detector's clear and step strobes, samples the detector's match flag after every step, and reports the match count and the first match index. It sits between the board switches/keys and the detector, so a whole 16-bit test word can be scanned with one start press instead of hand-clocking KEY[0].

---
 rtl/pattern_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Sequencer that scans a parallel word MSB-first into the serial 001/1010 pattern detector.
// Latency: one scan lasts 3 + WORD_W*(STEP_DIV+2) cycles from the accepted start to the end of DONE.
// Backpressure: none. A start is acted on only in IDLE, and a start seen while busy is dropped.
//
// Build option: define SCAN_STOP_ON_MATCH_EN to end the scan at the first detector match.
//
// Ports:
//   clock, reset      system clock; asynchronous active-low reset
//   start, word       scan request and the word it latches
//   det_match         detector match flag, valid in the cycle after det_step
//   det_bit           serial bit to the detector (shift register MSB)
//   det_step          one-cycle detector clock-enable strobe
//   det_clear         one-cycle detector synchronous clear strobe
//   busy, done        scan in progress; one-cycle end-of-scan pulse
//   found, match_cnt  at least one match; number of matches in the scan
//   first_idx         bit index (0 = MSB) of the first match, or 0 when there was none
module pattern_scan_ctrl #(
    parameter int WORD_W   = 16,
    parameter int STEP_DIV = 25000000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WORD_W-1:0]            word,
    input  logic                         det_match,
    output logic                         det_bit,
    output logic                         det_step,
    output logic                         det_clear,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [$clog2(WORD_W+1)-1:0]  match_cnt,
    output logic [$clog2(WORD_W)-1:0]    first_idx
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam int IW = $clog2(WORD_W);
    // A divider of 1 still needs a one-bit prescaler so the compare stays well formed.
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_STEP  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q,     state_d;
    logic [WORD_W-1:0]   shift_q,     shift_d;
    logic [CW-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [PW-1:0]       pre_q,       pre_d;
    logic                det_step_q,  det_step_d;
    logic                det_clear_q, det_clear_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                found_q,     found_d;
    logic [CW-1:0]       match_cnt_q, match_cnt_d;
    logic [IW-1:0]       first_idx_q, first_idx_d;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        pre_d       = pre_q;
        found_d     = found_q;
        match_cnt_d = match_cnt_q;
        first_idx_d = first_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d     = word;
                    bit_cnt_d   = '0;
                    match_cnt_d = '0;
                    found_d     = 1'b0;
                    first_idx_d = '0;
                    state_d     = S_CLEAR;
                end
            end

            S_CLEAR: begin
                pre_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (pre_q == PRE_LAST) begin
                    pre_d   = '0;
                    state_d = S_STEP;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end

            S_STEP: begin
                // The detector captures det_bit on this edge, so the next bit moves up behind it.
                shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CW'(1);
                state_d   = S_CHECK;
            end

            S_CHECK: begin
                if (det_match) begin
                    match_cnt_d = match_cnt_q + CW'(1);
                    if (!found_q) begin
                        found_d = 1'b1;
                        // bit_cnt already counts the bit just stepped, so the index is one less.
                        first_idx_d = IW'(bit_cnt_q - CW'(1));
                    end
                end
`ifdef SCAN_STOP_ON_MATCH_EN
                if (det_match || (bit_cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
`else
                if (bit_cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state and registered, so each one is high
        // in exactly the cycle its state occupies and never depends combinationally on an input.
        det_clear_d = (state_d == S_CLEAR);
        det_step_d  = (state_d == S_STEP);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d == S_CLEAR) || (state_d == S_WAIT) ||
                      (state_d == S_STEP)  || (state_d == S_CHECK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pre_q       <= '0;
            det_step_q  <= 1'b0;
            det_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            match_cnt_q <= '0;
            first_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            pre_q       <= pre_d;
            det_step_q  <= det_step_d;
            det_clear_q <= det_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            match_cnt_q <= match_cnt_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign det_bit   = shift_q[WORD_W-1];
    assign det_step  = det_step_q;
    assign det_clear = det_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign match_cnt = match_cnt_q;
    assign first_idx = first_idx_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl with a behavioural detector attached.
// Each accepted start pushes the expected scan outcome; a monitor checks strobes and results.
// Runs directed words from the test plan followed by random words.
module tb_pattern_scan_ctrl;

    localparam int W  = 16;
    localparam int D  = 2;
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);

    logic          clock;
    logic          reset;
    logic          start;
    logic [W-1:0]  word;
    logic          det_match;
    logic          det_bit;
    logic          det_step;
    logic          det_clear;
    logic          busy;
    logic          done;
    logic          found;
    logic [CW-1:0] match_cnt;
    logic [IW-1:0] first_idx;

    pattern_scan_ctrl #(.WORD_W(W), .STEP_DIV(D)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .word      (word),
        .det_match (det_match),
        .det_bit   (det_bit),
        .det_step  (det_step),
        .det_clear (det_clear),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .match_cnt (match_cnt),
        .first_idx (first_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural detector ----------------
    // Match when the last six bits are 001010; afterwards each further "10" pair
    // that directly follows a match (two steps later) is another overlapping match.
    logic [5:0] dh;
    int         dn;
    logic       mprev, mprev2;
    logic [5:0] h_t;
    logic       m_t;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            det_match <= 1'b0; dh <= '0; dn <= 0; mprev <= 1'b0; mprev2 <= 1'b0;
        end else if (det_clear) begin
            det_match <= 1'b0; dh <= '0; dn <= 0; mprev <= 1'b0; mprev2 <= 1'b0;
        end else if (det_step) begin
            h_t = {dh[4:0], det_bit};
            m_t = ((dn >= 5) && (h_t == 6'b001010)) || (mprev2 && (h_t[1:0] == 2'b10));
            dh        <= h_t;
            dn        <= dn + 1;
            det_match <= m_t;
            mprev2    <= mprev;
            mprev     <= m_t;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int           start;
        logic [W-1:0] word;
        int           found;
        int           cnt;
        int           first;
        int           steps;
    } exp_t;

    function automatic exp_t ref_scan(input logic [W-1:0] w, input int s);
        exp_t r;
        bit   b[W];
        bit   m[W];
        r.start = s; r.word = w; r.found = 0; r.cnt = 0; r.first = 0; r.steps = W;
        for (int i = 0; i < W; i++) b[i] = w[W-1-i];
        for (int i = 0; i < W; i++) begin
            m[i] = 1'b0;
            if (i >= 5 && {b[i-5], b[i-4], b[i-3], b[i-2], b[i-1], b[i]} == 6'b001010) m[i] = 1'b1;
            if (i >= 2 && m[i-2] && b[i-1] && !b[i]) m[i] = 1'b1;
            if (m[i]) begin
                r.cnt++;
                if (r.found == 0) begin
                    r.found = 1;
                    r.first = i;
                end
`ifdef SCAN_STOP_ON_MATCH_EN
                r.steps = i + 1;
                break;
`endif
            end
        end
        return r;
    endfunction

    function automatic int done_off(input exp_t e);
        return 2 + e.steps * (D + 2);
    endfunction

    exp_t sb[$];

    // ---------------- monitor ----------------
    int steps_seen = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (det_clear) begin
                steps_seen = 0;
                chk("clear_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) chk("clear_cycle", cyc, sb[0].start + 1);
                chk("busy_in_clear", int'(busy), 1);
            end
            if (det_step) begin
                if (sb.size() > 0) begin
                    if (steps_seen == 0) chk("first_step_cycle", cyc, sb[0].start + 2 + D);
                    if (steps_seen < W) chk("det_bit", int'(det_bit), int'(sb[0].word[W-1-steps_seen]));
                end
                steps_seen++;
            end
            if (done) begin
                chk("done_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.start + done_off(e));
                    chk("found", int'(found), e.found);
                    chk("match_cnt", int'(match_cnt), e.cnt);
                    chk("first_idx", int'(first_idx), e.first);
                    chk("step_count", steps_seen, e.steps);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic scan(input logic [W-1:0] w);
        @(posedge clock);
        #1;
        word  = w;
        start = 1'b1;
        sb.push_back(ref_scan(w, cyc));
        @(posedge clock);
        #1;
        start = 1'b0;
        word  = W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(posedge clock);
            n++;
        end
        chk("scan_completes", sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        int s;
        exp_t e;
        reset = 1'b1;
        start = 1'b0;
        word  = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_det_bit",   int'(det_bit), 0);
        chk("rst_det_step",  int'(det_step), 0);
        chk("rst_det_clear", int'(det_clear), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_done",      int'(done), 0);
        chk("rst_found",     int'(found), 0);
        chk("rst_match_cnt", int'(match_cnt), 0);
        chk("rst_first_idx", int'(first_idx), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // single match, multiple overlapping matches, no match
        scan(16'h2800); wait_idle();
        scan(16'h2A80); wait_idle();
        scan(16'hFFFF); wait_idle();

        // starts during a scan are dropped
        scan(16'h2800);
        s = sb[$].start;
        while (cyc < s + 10) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        while (cyc < s + 40) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_idle();

        // asynchronous reset mid-scan, then a clean scan
        scan(16'h2A80);
        s = sb[$].start;
        while (cyc < s + 30) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("abort_det_bit",   int'(det_bit), 0);
        chk("abort_det_step",  int'(det_step), 0);
        chk("abort_det_clear", int'(det_clear), 0);
        chk("abort_busy",      int'(busy), 0);
        chk("abort_found",     int'(found), 0);
        chk("abort_match_cnt", int'(match_cnt), 0);
        chk("abort_first_idx", int'(first_idx), 0);
        sb.delete();
        @(posedge clock); #1 reset = 1'b1;
        scan(16'h2A80); wait_idle();

        // start held high: a new scan begins the cycle after each done
        @(posedge clock);
        #1;
        word  = 16'h2800;
        start = 1'b1;
        s = cyc;
        for (int t = 0; t < 200; ) begin
            e = ref_scan(16'h2800, s + t);
            sb.push_back(e);
            t = t + done_off(e) + 1;
        end
        repeat (200) @(posedge clock);
        #1 start = 1'b0;
        wait_idle();

        // random words
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clock);
            scan(W'($urandom));
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
